// File: rtl/edge_event_bank.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_bank
// Purpose  : Per-channel synchroniser, debounce filter, edge qualifier with
//            one-cycle event pulse, sticky flag and combined interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module edge_event_bank #(
  parameter int   CH          = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 4,
  parameter logic RST_LEVEL   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH-1:0]     din,
  input  logic [2*CH-1:0]   mode,
  input  logic [CH-1:0]     evt_clr,
  input  logic [CH-1:0]     irq_en,
  output logic [CH-1:0]     filt,
  output logic [CH-1:0]     evt_pulse,
  output logic [CH-1:0]     evt_flag,
  output logic              irq
);

  localparam int                 c_CNT_W  = $clog2(FILT_LEN) + 1;
  localparam logic [c_CNT_W-1:0] c_THRESH = c_CNT_W'(FILT_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_filt;
    logic                   r_filt_prev;
    logic                   r_pulse;
    logic                   r_flag;
    logic                   w_sync_out;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_qual;
    logic [1:0]             w_mode;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_mode     = mode[2*i+1:2*i];
    assign w_rise     = r_filt & ~r_filt_prev;
    assign w_fall     = ~r_filt & r_filt_prev;
    // mode bit 0 enables rising, bit 1 enables falling; 11 therefore means both
    assign w_qual     = (w_mode[0] & w_rise) | (w_mode[1] & w_fall);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync      <= {SYNC_STAGES{RST_LEVEL}};
        r_cnt       <= '0;
        r_filt      <= RST_LEVEL;
        r_filt_prev <= RST_LEVEL;
        r_pulse     <= 1'b0;
        r_flag      <= 1'b0;
      end else begin
        r_sync      <= {r_sync[SYNC_STAGES-2:0], din[i]};
        r_filt_prev <= r_filt;
        if (w_sync_out == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == c_THRESH) begin
          r_filt <= ~r_filt;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + c_ONE;
        end
        r_pulse <= w_qual;
        // a new event beats a simultaneous write-1-to-clear
        r_flag  <= w_qual | (r_flag & ~evt_clr[i]);
      end
    end

    assign filt[i]      = r_filt;
    assign evt_pulse[i] = r_pulse;
    assign evt_flag[i]  = r_flag;
  end

  assign irq = |(evt_flag & irq_en);

endmodule
`default_nettype wire

// File: tb/tb_edge_event_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_event_bank
// Purpose  : Directed self-checking bench for edge_event_bank (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_event_bank;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic [7:0] mode;
  logic [3:0] evt_clr;
  logic [3:0] irq_en;
  logic [3:0] filt;
  logic [3:0] evt_pulse;
  logic [3:0] evt_flag;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;

  edge_event_bank #(
    .CH(4), .SYNC_STAGES(2), .FILT_LEN(4), .RST_LEVEL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .evt_clr(evt_clr),
    .irq_en(irq_en), .filt(filt), .evt_pulse(evt_pulse),
    .evt_flag(evt_flag), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // After the n-th step following a din change we sit just after edge n-1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    din = 4'hF; mode = 8'h00; evt_clr = 4'h0; irq_en = 4'hF; rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if (filt !== 4'hF || evt_pulse !== 4'h0 || evt_flag !== 4'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state filt=%h pulse=%h flag=%h irq=%b exp F/0/0/0", filt, evt_pulse, evt_flag, irq);
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      n_checks++;
      if (filt !== 4'hF || evt_pulse !== 4'h0 || evt_flag !== 4'h0 || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset k=%0d filt=%h pulse=%h flag=%h irq=%b exp F/0/0/0", k, filt, evt_pulse, evt_flag, irq);
      end
    end
  endtask

  task automatic test_rise_latency();
    mode = 8'b00_00_00_01;
    din[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if (evt_pulse[0] !== 1'b0 || evt_flag[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL fall_no_pulse k=%0d pulse=%b flag=%b exp 0/0", k, evt_pulse[0], evt_flag[0]);
      end
    end
    n_checks++;
    if (filt[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_filt got=%b exp=0", filt[0]);
    end
    din[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if (filt[0] !== (k >= 6) || evt_pulse[0] !== (k == 7) || evt_flag[0] !== (k >= 7)) begin
        n_fail++;
        $display("FAIL rise_latency k=%0d filt=%b pulse=%b flag=%b exp %b/%b/%b",
                 k, filt[0], evt_pulse[0], evt_flag[0], k >= 6, k == 7, k >= 7);
      end
    end
  endtask

  task automatic test_debounce();
    mode = 8'b00_00_11_01;
    din[1] = 1'b0;
    step(); step(); step();
    din[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if (filt[1] !== 1'b1 || evt_pulse[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL short_glitch k=%0d filt=%b pulse=%b exp 1/0", k, filt[1], evt_pulse[1]);
      end
    end
    din[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if (filt[1] !== (k < 6) || evt_pulse[1] !== (k == 7)) begin
        n_fail++;
        $display("FAIL fall_4cyc k=%0d filt=%b pulse=%b exp %b/%b", k, filt[1], evt_pulse[1], k < 6, k == 7);
      end
    end
    // one-cycle low bounce at edge 2 restarts the count; filt moves at edge 8
    for (int k = 1; k <= 14; k++) begin
      din[1] = (k == 3) ? 1'b0 : 1'b1;
      step();
      n_checks++;
      if (filt[1] !== (k >= 9) || evt_pulse[1] !== (k == 10)) begin
        n_fail++;
        $display("FAIL bounce_restart k=%0d filt=%b pulse=%b exp %b/%b", k, filt[1], evt_pulse[1], k >= 9, k == 10);
      end
    end
  endtask

  task automatic test_multi_channel();
    logic [1:0] lvl;
    logic [1:0] old;
    mode = 8'b00_11_11_01;
    lvl = 2'b11;
    for (int t = 0; t < 3; t++) begin
      old = lvl;
      lvl = ~lvl;
      din[3:2] = lvl;
      for (int k = 1; k <= 8; k++) begin
        step();
        n_checks++;
        if (filt[3:2] !== ((k >= 6) ? lvl : old) || evt_pulse[2] !== (k == 7) ||
            evt_pulse[3] !== 1'b0 || evt_flag[3] !== 1'b0 || evt_flag[2] !== (k >= 7 || t > 0)) begin
          n_fail++;
          $display("FAIL multi t=%0d k=%0d filt=%b pulse=%b flag=%b", t, k, filt[3:2], evt_pulse[3:2], evt_flag[3:2]);
        end
      end
    end
  endtask

  task automatic test_flag_clear();
    evt_clr = 4'hF;
    step();
    evt_clr = 4'h0;
    n_checks++;
    if (evt_flag !== 4'h0) begin
      n_fail++;
      $display("FAIL clear_all got=%h exp=0", evt_flag);
    end
    irq_en = 4'h1;
    din[0] = 1'b0; repeat (8) step();
    din[0] = 1'b1; repeat (8) step();
    n_checks++;
    if (evt_flag[0] !== 1'b1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL flag_set flag=%b irq=%b exp 1/1", evt_flag[0], irq);
    end
    din[0] = 1'b0; repeat (8) step();
    din[0] = 1'b1; repeat (6) step();
    evt_clr[0] = 1'b1;
    step();
    n_checks++;
    if (evt_pulse[0] !== 1'b1 || evt_flag[0] !== 1'b1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL set_beats_clear pulse=%b flag=%b irq=%b exp 1/1/1", evt_pulse[0], evt_flag[0], irq);
    end
    step();
    evt_clr[0] = 1'b0;
    n_checks++;
    if (evt_pulse[0] !== 1'b0 || evt_flag[0] !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_alone pulse=%b flag=%b irq=%b exp 0/0/0", evt_pulse[0], evt_flag[0], irq);
    end
    irq_en = 4'h0;
    din[0] = 1'b0; repeat (8) step();
    din[0] = 1'b1; repeat (8) step();
    n_checks++;
    if (evt_flag[0] !== 1'b1 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_masked flag=%b irq=%b exp 1/0", evt_flag[0], irq);
    end
    irq_en = 4'hF;
    #1;
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_unmask got=%b exp=1", irq);
    end
  endtask

  task automatic test_reset_mid();
    mode = 8'b00_11_11_11;
    din[0] = 1'b0;
    repeat (4) step();
    n_checks++;
    if (filt[0] !== 1'b1 || evt_flag[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset filt=%b flag=%b exp 1/1", filt[0], evt_flag[0]);
    end
    din = 4'hF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (filt !== 4'hF || evt_pulse !== 4'h0 || evt_flag !== 4'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset filt=%h pulse=%h flag=%h irq=%b exp F/0/0/0", filt, evt_pulse, evt_flag, irq);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if (filt !== 4'hF || evt_pulse !== 4'h0 || evt_flag !== 4'h0) begin
        n_fail++;
        $display("FAIL post_reset_idle k=%0d filt=%h pulse=%h flag=%h", k, filt, evt_pulse, evt_flag);
      end
    end
    din[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (filt[0] !== (k < 6) || evt_pulse[0] !== (k == 7) || evt_flag[0] !== (k >= 7)) begin
        n_fail++;
        $display("FAIL post_reset_edge k=%0d filt=%b pulse=%b flag=%b exp %b/%b/%b",
                 k, filt[0], evt_pulse[0], evt_flag[0], k < 6, k == 7, k >= 7);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_debounce();
    test_multi_channel();
    test_flag_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_event_bank.md
Name: edge_event_bank

Overview:
Multi-channel successor to the single-channel rising-edge detector. Each channel has a synchroniser, a debounce filter, a per-channel edge-mode selector (rising, falling, both or off), a one-cycle event pulse and a sticky event flag. A combined interrupt is raised from the flags. The block sits between raw serial/encoder/GPIO pins and the control/status logic of the SPI/UART/I2C blocks.

Parameters:
CH, 4, number of independent channels (1..32)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_LEN, 4, consecutive stable cycles needed to accept a new level (>=1)
RST_LEVEL, 1, reset value of synchroniser and filtered level (all channels)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
din  in  CH  raw asynchronous inputs
mode  in  2*CH  per-channel edge select, channel i at [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
evt_clr  in  CH  write-1-to-clear for evt_flag
irq_en  in  CH  per-channel interrupt enable
filt  out  CH  debounced level
evt_pulse  out  CH  one-cycle pulse per qualified edge
evt_flag  out  CH  sticky event flag
irq  out  1  OR over (evt_flag & irq_en)

Behaviour:
- Reset is synchronous, active-high, one clock; clk is the only clock:
  - synchroniser flops = RST_LEVEL
  - filt = RST_LEVEL, filter counters = 0
  - evt_pulse = 0, evt_flag = 0, irq = 0
- Reset state equals the idle pin level, so leaving reset with din at RST_LEVEL produces no event.
- Synchroniser: plain SYNC_STAGES-deep shift register per channel; sync_out is the last stage.
- Filter per channel, counter width $clog2(FILT_LEN)+1:
  - sync_out == filt: counter cleared to 0.
  - sync_out != filt and counter == FILT_LEN-1: filt toggles, counter cleared.
  - Otherwise counter increments.
  - Any return to the filt level before the threshold (a bounce) clears the counter. Pulses shorter than FILT_LEN cycles at sync_out never reach filt.
- Edge qualification, registered:
  - evt_pulse[i] is set on the edge after filt[i] changes, for exactly one cycle.
  - rise = filt & ~filt_prev; fall = ~filt & filt_prev.
  - Pulse when (mode 01 & rise) | (mode 10 & fall) | (mode 11 & (rise|fall)); mode 00 never pulses.
  - Mode is sampled at the qualification edge only. Changing mode never creates or cancels a pulse by itself.
- Latency: count the first clk edge that samples the new din level as edge 0.
  - filt changes at edge SYNC_STAGES+FILT_LEN-1.
  - evt_pulse is high after edge SYNC_STAGES+FILT_LEN, for one cycle.
  - With defaults: filt at edge 5, pulse after edge 6.
- Minimum spacing: two edges on one channel are at least FILT_LEN cycles apart, so pulses never merge.
- evt_flag[i]:
  - Set on the edge where evt_pulse[i] is registered high, i.e. it rises together with the pulse.
  - Cleared on an edge with evt_clr[i]=1.
  - Set wins over a simultaneous clear.
  - Holds otherwise.
- irq is combinational from the registered evt_flag and the irq_en input. It is glitch-free with respect to din.
- Channels are fully independent; simultaneous events on several channels are all captured.
- Reset mid-debounce discards partial counts and any pending pulse. After release the channel behaves as a fresh start from RST_LEVEL.
- No combinational path from din to any output.

Test Plan:
1. Defaults, din=4'hF through reset and 20 cycles after release -> filt=4'hF, evt_pulse=0, evt_flag=0, irq=0 throughout.
2. mode[1:0]=01, din[0]: 1->0 held 10 cycles, then 0->1 held -> no pulse on the fall. On the rise, filt[0]=1 after edge 5 and evt_pulse[0]=1 for exactly one cycle after edge 6. evt_flag[0]=1 from then on.
3. mode ch1=11, din[1] low for 3 cycles then high -> filt[1] stays 1, no pulse. Then low for 4 cycles -> filt[1] falls, one pulse. Then a 1-cycle bounce high mid-count -> counter restarts, filt change delayed accordingly.
4. mode ch2=11, ch3=00, din[3:2] toggled together, each level held 8 cycles -> ch2 one pulse per transition, ch3 filt follows but evt_pulse[3] and evt_flag[3] stay 0.
5. evt_flag[0]=1, irq_en=4'h1: assert evt_clr[0] on the same edge as a new evt_pulse[0] -> flag stays 1, irq=1. evt_clr[0] alone next cycle -> flag 0, irq 0. Same with irq_en=0 -> irq stays 0 regardless of flags.
6. Assert rst for 1 cycle while ch0 counter is at 2 and flags are set -> all outputs return to reset values next cycle. No pulse appears for the interrupted transition. A subsequent clean edge is detected with the normal latency.
